// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS responder peripherals: timer register
// offsets, CTRL field positions and the packed CTRL layout.
package otter_io_pkg;

  // Word select (IOBUS_ADDR[3:2]) of each timer register
  localparam logic [1:0] TMR_CTRL    = 2'd0;
  localparam logic [1:0] TMR_COUNT   = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AR_BIT     = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int CTRL_PS_LSB     = 8;
  localparam int CTRL_PS_MSB     = 15;
  localparam int STATUS_MATCH_BIT = 0;

  typedef struct packed {
    logic [7:0] prescale;
    logic       int_en;
    logic       auto_reload;
    logic       en;
  } tmr_ctrl_t;

  // Extract the implemented CTRL fields from a bus word
  function automatic tmr_ctrl_t ctrl_from_word(input logic [31:0] w);
    tmr_ctrl_t c;
    c.prescale    = w[CTRL_PS_MSB:CTRL_PS_LSB];
    c.int_en      = w[CTRL_IE_BIT];
    c.auto_reload = w[CTRL_AR_BIT];
    c.en          = w[CTRL_EN_BIT];
    return c;
  endfunction

  // Rebuild the bus view of CTRL; unimplemented bits read 0
  function automatic logic [31:0] ctrl_to_word(input tmr_ctrl_t c);
    logic [31:0] w;
    w = 32'h0;
    w[CTRL_PS_MSB:CTRL_PS_LSB] = c.prescale;
    w[CTRL_IE_BIT]             = c.int_en;
    w[CTRL_AR_BIT]             = c.auto_reload;
    w[CTRL_EN_BIT]             = c.en;
    return w;
  endfunction

endpackage

// File: rtl/otter_prescaler.sv
// Programmable 8-bit prescaler: with en high, asserts tick for one cycle
// every prescale+1 cycles. clear restarts the phase at zero.
module otter_prescaler (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic [7:0] prescale,
  input  logic       clear,
  output logic       tick
);

  logic [7:0] ps_reg;

  // Tick is taken in the cycle the phase counter reaches the terminal value
  assign tick = en && (ps_reg == prescale);

  // Phase counter: wraps on tick, holds while disabled, clear has priority
  always_ff @(posedge clk) begin
    if (srst) begin
      ps_reg <= 8'd0;
    end else if (clear) begin
      ps_reg <= 8'd0;
    end else if (en) begin
      ps_reg <= tick ? 8'd0 : ps_reg + 8'd1;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// OTTER IOBUS timer: 16-byte register window holding CTRL, COUNT, COMPARE
// and STATUS; prescaled 32-bit up-counter with compare match, optional
// auto-reload and a level interrupt. Reads are zero-wait-state and return
// 0 outside the window so several responders can be OR-combined.
module otter_iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0300
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TMR_INT
);

  tmr_ctrl_t   ctrl_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        match_reg;

  logic        hit;
  logic [1:0]  sel;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;
  logic        tick;
  logic        match_set;
  logic        unused_addr_bits;

  // Word-only access: byte offset bits are deliberately ignored
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign hit        = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign sel        = IOBUS_ADDR[3:2];
  assign wr_ctrl    = IOBUS_WR && hit && (sel == TMR_CTRL);
  assign wr_count   = IOBUS_WR && hit && (sel == TMR_COUNT);
  assign wr_compare = IOBUS_WR && hit && (sel == TMR_COMPARE);
  assign wr_status  = IOBUS_WR && hit && (sel == TMR_STATUS);

  otter_prescaler u_prescaler (
    .clk      (CLK),
    .srst     (RESET),
    .en       (ctrl_reg.en),
    .prescale (ctrl_reg.prescale),
    .clear    (wr_ctrl),
    .tick     (tick)
  );

  // A COUNT write in a tick cycle suppresses both increment and match
  assign match_set = tick && !wr_count && (count_reg == compare_reg);

  // CTRL register; the tick of this cycle already used the old fields
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_reg <= '0;
    end else if (wr_ctrl) begin
      ctrl_reg <= ctrl_from_word(IOBUS_OUT);
    end
  end

  // Counter: bus write wins, otherwise advance (or reload on match) per tick
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_reg <= 32'h0;
    end else if (wr_count) begin
      count_reg <= IOBUS_OUT;
    end else if (tick) begin
      if (match_set && ctrl_reg.auto_reload) begin
        count_reg <= 32'h0;
      end else begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // COMPARE register; a match in the same cycle compares against the old value
  always_ff @(posedge CLK) begin
    if (RESET) begin
      compare_reg <= 32'hFFFF_FFFF;
    end else if (wr_compare) begin
      compare_reg <= IOBUS_OUT;
    end
  end

  // Sticky MATCH flag: a new match beats a write-1-to-clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      match_reg <= 1'b0;
    end else if (match_set) begin
      match_reg <= 1'b1;
    end else if (wr_status && IOBUS_OUT[STATUS_MATCH_BIT]) begin
      match_reg <= 1'b0;
    end
  end

  assign TMR_INT = match_reg && ctrl_reg.int_en;

  // Read mux: selected register inside the window, zero elsewhere
  always_comb begin
    IOBUS_IN = 32'h0;
    if (hit) begin
      case (sel)
        TMR_CTRL:    IOBUS_IN = ctrl_to_word(ctrl_reg);
        TMR_COUNT:   IOBUS_IN = count_reg;
        TMR_COMPARE: IOBUS_IN = compare_reg;
        default:     IOBUS_IN = {31'h0, match_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: a cycle-level reference model
// built from the register rules, directed scenarios with literal
// expectations, then randomized bus traffic checked every cycle.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat, rdat;
  logic        wr;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  otter_iobus_timer #(.BASE_ADDR(BASE)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .IOBUS_ADDR (addr),
    .IOBUS_OUT  (wdat),
    .IOBUS_WR   (wr),
    .IOBUS_IN   (rdat),
    .TMR_INT    (irq)
  );

  // ---------------- reference model ----------------
  bit          m_valid = 0;
  bit          m_en, m_ar, m_ie, m_match;
  int          m_pre, m_phase;
  logic [31:0] m_count, m_cmp;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return (m_pre << 8) | (m_ie << 2) | (m_ar << 1) | m_en;
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'h0, m_match};
    endcase
  endfunction

  task automatic m_step(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w);
    bit hit, tick, hit_cmp;
    int s;
    if (r) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_pre = 0; m_phase = 0;
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_valid = 1;
      return;
    end
    hit  = (a[31:4] == BASE[31:4]) && w;
    s    = a[3:2];
    tick = m_en && (m_phase == m_pre);
    hit_cmp = tick && !(hit && s == 1) && (m_count == m_cmp);
    // phase
    if (hit && s == 0) m_phase = 0;
    else if (m_en) m_phase = tick ? 0 : m_phase + 1;
    // counter (uses old AUTO_RELOAD and COMPARE)
    if (hit && s == 1) m_count = d;
    else if (tick) m_count = (hit_cmp && m_ar) ? 32'h0 : m_count + 32'd1;
    // status
    if (hit_cmp) m_match = 1;
    else if (hit && s == 3 && d[0]) m_match = 0;
    if (hit && s == 2) m_cmp = d;
    if (hit && s == 0) begin
      m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_pre = int'(d[15:8]);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus transaction: drive after negedge, check combinational outputs
  // against the model, then advance the model on the rising edge.
  task automatic do_cycle(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w,
                          output logic [31:0] rd, output logic ir);
    @(negedge clk);
    rst = r; addr = a; wdat = d; wr = w;
    #1;
    rd = rdat; ir = irq;
    $display("t=%0t rst=%0b wr=%0b addr=%h wdata=%h rdata=%h int=%0b", $time, r, w, a, d, rdat, irq);
    if (m_valid) begin
      check32("model_iobus_in", rdat, m_read(a));
      check32("model_tmr_int", {31'h0, irq}, {31'h0, m_match & m_ie});
    end
    @(posedge clk);
    m_step(r, a, d, w);
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] rd; logic ir;
    do_cycle(0, BASE | {28'h0, off}, d, 1, rd, ir);
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic ir;
    do_cycle(0, a, 32'h0, 0, rd, ir);
    check32(name, rd, exp);
  endtask

  task automatic int_lit(input string name, input logic exp);
    logic [31:0] rd; logic ir;
    do_cycle(0, BASE | 32'hC, 32'h0, 0, rd, ir);
    check32(name, {31'h0, ir}, {31'h0, exp});
  endtask

  task automatic do_reset();
    logic [31:0] rd; logic ir;
    do_cycle(1, BASE | 32'h4, 32'h1234_5678, 1, rd, ir);
  endtask

  initial begin
    logic [31:0] rd, d, a, rnd;
    logic ir;
    int sel;
    logic [31:0] exp_pre [16];

    rst = 1; addr = 0; wdat = 0; wr = 0;
    do_reset();
    do_reset();

    // Reset values
    rd_lit("rst_ctrl",    BASE | 32'h0, 32'h0);
    rd_lit("rst_count",   BASE | 32'h4, 32'h0);
    rd_lit("rst_compare", BASE | 32'h8, 32'hFFFF_FFFF);
    rd_lit("rst_status",  BASE | 32'hC, 32'h0);
    rd_lit("outside",     BASE + 32'h10, 32'h0);
    int_lit("rst_int", 1'b0);

    // PRESCALE=0, auto-reload, interrupt enabled, COMPARE=5
    wr_reg(4'h8, 32'd5);
    wr_reg(4'h0, 32'h0000_0007);
    for (int i = 0; i <= 5; i++) rd_lit("reload_count", BASE | 32'h4, i);
    rd_lit("reload_wrap0", BASE | 32'h4, 32'h0);
    rd_lit("reload_match", BASE | 32'hC, 32'h1);
    int_lit("reload_int", 1'b1);
    wr_reg(4'h0, 32'h0);
    wr_reg(4'hC, 32'h1);
    rd_lit("clear_status", BASE | 32'hC, 32'h0);

    // Clear in the same edge as a new match: set wins
    wr_reg(4'h4, 32'd3);
    wr_reg(4'h8, 32'd3);
    wr_reg(4'h0, 32'h0000_0005);
    wr_reg(4'hC, 32'h1);
    rd_lit("set_wins", BASE | 32'hC, 32'h1);
    wr_reg(4'h0, 32'h0000_0004);
    wr_reg(4'hC, 32'h0);
    rd_lit("write0_noeffect", BASE | 32'hC, 32'h1);
    int_lit("int_held", 1'b1);
    wr_reg(4'hC, 32'h1);
    int_lit("int_dropped", 1'b0);

    // Wrap-around without match
    wr_reg(4'h0, 32'h0);
    wr_reg(4'h4, 32'hFFFF_FFFE);
    wr_reg(4'h8, 32'd7);
    wr_reg(4'h0, 32'h0000_0001);
    rd_lit("wrap_a", BASE | 32'h4, 32'hFFFF_FFFE);
    rd_lit("wrap_b", BASE | 32'h4, 32'hFFFF_FFFF);
    rd_lit("wrap_c", BASE | 32'h4, 32'h0);
    rd_lit("wrap_d", BASE | 32'h4, 32'h1);
    rd_lit("wrap_nomatch", BASE | 32'hC, 32'h0);

    // PRESCALE=3, no reload, INT_EN=0, COMPARE=2
    wr_reg(4'h0, 32'h0);
    wr_reg(4'h4, 32'h0);
    wr_reg(4'h8, 32'd2);
    wr_reg(4'h0, 32'h0000_0301);
    for (int i = 0; i < 16; i++) exp_pre[i] = i / 4;
    for (int i = 0; i < 16; i++) rd_lit("ps3_count", BASE | 32'h4, exp_pre[i]);
    rd_lit("ps3_match", BASE | 32'hC, 32'h1);
    int_lit("ps3_noint", 1'b0);

    // COUNT write on a tick cycle wins; then reset mid-count
    wr_reg(4'h0, 32'h0000_0001);
    wr_reg(4'h4, 32'd100);
    rd_lit("count_wr_wins", BASE | 32'h4, 32'd100);
    do_reset();
    rd_lit("mid_rst_ctrl",    BASE | 32'h0, 32'h0);
    rd_lit("mid_rst_count",   BASE | 32'h4, 32'h0);
    rd_lit("mid_rst_compare", BASE | 32'h8, 32'hFFFF_FFFF);
    rd_lit("mid_rst_status",  BASE | 32'hC, 32'h0);

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 2500; n++) begin
      rnd = $urandom;
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h10 * $urandom_range(1, 200);
      else a = BASE | (sel << 2) | (rnd & 32'h3);
      d = $urandom;
      case (sel)
        0: d = (d & 32'hFFFF_00FF) | ($urandom_range(0, 3) << 8);
        1: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 20);
        2: d = $urandom_range(0, 20);
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else do_cycle(0, a, d, $urandom_range(0, 7) == 0, rd, ir);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
